// File: rtl/myo_pkg.sv
// Shared types and constants for the myocontrol SPI poller.
package myo_pkg;

    localparam int unsigned SPI_WORD_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StShift = 2'd2,
        StGap   = 2'd3
    } state_e;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h01;
    localparam logic [7:0] ADDR_MASK     = 8'h02;
    localparam logic [7:0] ADDR_SETPOINT = 8'h10;
    localparam logic [7:0] ADDR_RX       = 8'h40;

    // Index width for an n-entry structure, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/myo_spi_shifter.sv
// One 16-bit SPI mode-1 word engine: sck idles low, mosi changes on sck rise, miso is
// sampled on sck fall. Each bit is CLK_DIV cycles high then CLK_DIV cycles low, so the
// word ends with a full low half-period. done_o is high in the last cycle of the word and
// start_i may be raised in that same cycle to chain the next word without a bubble.
module myo_spi_shifter
    import myo_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [SPI_WORD_W-1:0] tx_word_i,
    input  logic                  miso_i,
    output logic                  sck_o,
    output logic                  mosi_o,
    output logic                  done_o,
    output logic [SPI_WORD_W-1:0] rx_word_o
);

    localparam int unsigned DivW = idx_width(CLK_DIV);
    localparam int unsigned BitW = idx_width(SPI_WORD_W);

    logic                  active_q, high_q, sck_q, mosi_q;
    logic [DivW-1:0]       div_q;
    logic [BitW-1:0]       bit_q;
    logic [SPI_WORD_W-1:0] tx_q, rx_q;
    logic                  div_last;

    assign div_last  = (div_q == DivW'(CLK_DIV - 1));
    assign done_o    = active_q && !high_q && div_last && (bit_q == BitW'(SPI_WORD_W - 1));
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;
    assign rx_word_o = rx_q;

    // Half-period divider, bit counter and shift registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            high_q   <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else if (abort_i) begin
            active_q <= 1'b0;
            high_q   <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
        end else if (start_i) begin
            active_q <= 1'b1;
            high_q   <= 1'b1;
            sck_q    <= 1'b1;
            div_q    <= '0;
            bit_q    <= '0;
            mosi_q   <= tx_word_i[SPI_WORD_W-1];
            tx_q     <= {tx_word_i[SPI_WORD_W-2:0], 1'b0};
        end else if (active_q) begin
            if (div_last) begin
                div_q <= '0;
                if (high_q) begin
                    sck_q  <= 1'b0;
                    high_q <= 1'b0;
                    rx_q   <= {rx_q[SPI_WORD_W-2:0], miso_i};
                end else if (bit_q == BitW'(SPI_WORD_W - 1)) begin
                    active_q <= 1'b0;
                    mosi_q   <= 1'b0;
                end else begin
                    bit_q  <= bit_q + 1'b1;
                    sck_q  <= 1'b1;
                    high_q <= 1'b1;
                    mosi_q <= tx_q[SPI_WORD_W-1];
                    tx_q   <= {tx_q[SPI_WORD_W-2:0], 1'b0};
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/myo_spi_poller.sv
// Round-robin SPI poller for NUM_MOTORS motor boards with an Avalon-MM register bank.
// Optional build macro MYO_POWER_SENSE_EN: synchronised power_sense_n gates and aborts
// frames and is reported in STATUS[1]; without it power_sense_n is ignored.
module myo_spi_poller
    import myo_pkg::*;
#(
    parameter int unsigned NUM_MOTORS  = 6,
    parameter int unsigned FRAME_WORDS = 4,
    parameter int unsigned CLK_DIV     = 25,
    parameter int unsigned GAP_CYCLES  = 50
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_MOTORS-1:0] ss_n_o,
    input  logic                  power_sense_n
);

    localparam int unsigned MotW  = idx_width(NUM_MOTORS);
    localparam int unsigned WordW = idx_width(FRAME_WORDS);
    localparam int unsigned RxN   = NUM_MOTORS * FRAME_WORDS;
    localparam int unsigned RxW   = idx_width(RxN);
    localparam int unsigned CntW  = 16;

    logic                  enable_q;
    logic [NUM_MOTORS-1:0] mask_q;
    logic [15:0]           setpoint_q [NUM_MOTORS];
    logic [15:0]           rx_q       [RxN];
    logic [15:0]           shadow_q   [FRAME_WORDS];
    state_e                state_q;
    logic [MotW-1:0]       motor_q, pick_lo, pick_incl, pick_excl;
    logic [WordW-1:0]      word_q;
    logic [CntW-1:0]       cnt_q;
    logic [15:0]           frame_cnt_q;
    logic                  commit_q;
    logic [NUM_MOTORS-1:0] ss_n_q;
    logic [31:0]           rdata_q, rd_data;
    logic                  found_lo, found_incl, found_excl;
    logic                  power_ok, status_pwr, run_ok, in_frame;
    logic                  sh_start, sh_abort, sh_done;
    logic [15:0]           sh_tx, sh_rx;
    logic [7:0]            sp_off, rx_off;
    logic                  unused_wdata;

    assign unused_wdata = ^avs_writedata[31:16];

`ifdef MYO_POWER_SENSE_EN
    logic [1:0] pwr_sync_q;

    // Two-flop synchroniser; resets to "no power" so nothing runs until power is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pwr_sync_q <= 2'b11;
        else          pwr_sync_q <= {pwr_sync_q[0], power_sense_n};
    end

    assign power_ok   = ~pwr_sync_q[1];
    assign status_pwr = power_ok;
`else
    logic unused_power_sense;
    assign unused_power_sense = power_sense_n;
    assign power_ok           = 1'b1;
    assign status_pwr         = 1'b0;
`endif

    assign run_ok   = enable_q && (|mask_q) && power_ok;
    assign in_frame = (state_q == StSetup) || (state_q == StShift);
    assign sh_abort = in_frame && !power_ok;
    assign sh_start = power_ok &&
                      (((state_q == StSetup) && (cnt_q == CntW'(CLK_DIV - 1))) ||
                       ((state_q == StShift) && sh_done && (word_q != WordW'(FRAME_WORDS - 1))));
    // Only word 0 carries the setpoint; it is taken at the SETUP->SHIFT edge.
    assign sh_tx    = (state_q == StSetup) ? setpoint_q[motor_q] : '0;

    assign ss_n_o       = ss_n_q;
    assign avs_readdata = rdata_q;

    myo_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .start_i   (sh_start),
        .abort_i   (sh_abort),
        .tx_word_i (sh_tx),
        .miso_i    (miso),
        .sck_o     (sck),
        .mosi_o    (mosi),
        .done_o    (sh_done),
        .rx_word_o (sh_rx)
    );

    // Round-robin candidates: first masked index at/after, and strictly after, the current one.
    always_comb begin
        pick_lo    = '0;
        pick_incl  = '0;
        pick_excl  = '0;
        found_lo   = 1'b0;
        found_incl = 1'b0;
        found_excl = 1'b0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (mask_q[i]) begin
                if (!found_lo) begin
                    pick_lo  = MotW'(i);
                    found_lo = 1'b1;
                end
                if (!found_incl && (i >= int'(motor_q))) begin
                    pick_incl  = MotW'(i);
                    found_incl = 1'b1;
                end
                if (!found_excl && (i > int'(motor_q))) begin
                    pick_excl  = MotW'(i);
                    found_excl = 1'b1;
                end
            end
        end
        if (!found_incl) pick_incl = pick_lo;
        if (!found_excl) pick_excl = pick_lo;
    end

    // Host-writable registers; RO and unmapped addresses are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= 1'b0;
            mask_q   <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) setpoint_q[i] <= '0;
        end else if (avs_write) begin
            if (avs_address == ADDR_CTRL) begin
                enable_q <= avs_writedata[0];
            end else if (avs_address == ADDR_MASK) begin
                mask_q <= NUM_MOTORS'(avs_writedata);
            end else if ((avs_address >= ADDR_SETPOINT) && (sp_off < 8'(NUM_MOTORS))) begin
                setpoint_q[MotW'(sp_off)] <= avs_writedata[15:0];
            end
        end
    end

    // Read decode.
    always_comb begin
        rd_data = '0;
        sp_off  = avs_address - ADDR_SETPOINT;
        rx_off  = avs_address - ADDR_RX;
        if (avs_address == ADDR_CTRL) begin
            rd_data[0] = enable_q;
        end else if (avs_address == ADDR_STATUS) begin
            rd_data[0]     = (state_q != StIdle);
            rd_data[1]     = status_pwr;
            rd_data[13:8]  = 6'(motor_q);
            rd_data[31:16] = frame_cnt_q;
        end else if (avs_address == ADDR_MASK) begin
            rd_data = 32'(mask_q);
        end else if ((avs_address >= ADDR_SETPOINT) && (sp_off < 8'(NUM_MOTORS))) begin
            rd_data = {16'h0, setpoint_q[MotW'(sp_off)]};
        end else if ((avs_address >= ADDR_RX) && (32'(rx_off) < RxN)) begin
            rd_data = {16'h0, rx_q[RxW'(rx_off)]};
        end
    end

    // Read data register, one cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      rdata_q <= '0;
        else if (avs_read) rdata_q <= rd_data;
    end

    // Frame sequencer; owns the RX bank and frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            motor_q     <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
            ss_n_q      <= '1;
            commit_q    <= 1'b0;
            frame_cnt_q <= '0;
            for (int i = 0; i < FRAME_WORDS; i++) shadow_q[i] <= '0;
            for (int i = 0; i < RxN; i++) rx_q[i] <= '0;
        end else begin
            // Commit runs in the first GAP cycle, so a read issued then still sees old data.
            if (commit_q) begin
                for (int w = 0; w < FRAME_WORDS; w++) begin
                    rx_q[RxW'(int'(motor_q) * FRAME_WORDS + w)] <= shadow_q[w];
                end
                frame_cnt_q <= frame_cnt_q + 16'd1;
                commit_q    <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (run_ok) begin
                        motor_q <= pick_incl;
                        ss_n_q  <= ~(NUM_MOTORS'(1) << pick_incl);
                        cnt_q   <= '0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (!power_ok) begin
                        ss_n_q  <= '1;
                        cnt_q   <= '0;
                        state_q <= StGap;
                    end else if (cnt_q == CntW'(CLK_DIV - 1)) begin
                        word_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StShift: begin
                    if (!power_ok) begin
                        ss_n_q  <= '1;
                        cnt_q   <= '0;
                        state_q <= StGap;
                    end else if (sh_done) begin
                        shadow_q[word_q] <= sh_rx;
                        if (word_q == WordW'(FRAME_WORDS - 1)) begin
                            ss_n_q   <= '1;
                            cnt_q    <= '0;
                            commit_q <= 1'b1;
                            state_q  <= StGap;
                        end else begin
                            word_q <= word_q + 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                        cnt_q <= '0;
                        if (run_ok) begin
                            motor_q <= pick_excl;
                            ss_n_q  <= ~(NUM_MOTORS'(1) << pick_excl);
                            state_q <= StSetup;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_myo_spi_poller.sv
// Directed bench for myo_spi_poller with a four-word SPI slave model per motor.
module tb_myo_spi_poller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        sck, mosi;
    logic        miso = 1'b0;
    logic [5:0]  ss_n_o;
    logic        power_sense_n = 1'b0;

    myo_spi_poller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .sck           (sck),
        .mosi          (mosi),
        .miso          (miso),
        .ss_n_o        (ss_n_o),
        .power_sense_n (power_sense_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Frame log written by the slave model at each ss_n release.
    logic [5:0]  log_ssn [$];
    logic [15:0] log_w0  [$];
    int          log_bits[$];

    logic        in_frame = 1'b0;
    logic [5:0]  cur_ssn;
    logic [63:0] cap, sl_sh;
    int          nbits = 0, nrise = 0;
    int          t_fall = 0, t_r0 = 0, t_lastfall = 0, t_ssrise = 0;
    int          setup_lat = -1, sck_period = -1, sck_high = -1, tail = -1, gap = -1;
    int          multi_sel = 0;

    always @(ss_n_o) begin
        if (reset_n === 1'b1 && ss_n_o != 6'h3F && !in_frame) begin
            in_frame = 1'b1;
            cur_ssn  = ss_n_o;
            cap      = '0;
            nbits    = 0;
            t_fall   = cyc;
            if (log_ssn.size() == 1 && gap < 0) gap = cyc - t_ssrise;
            case (ss_n_o)
                6'b111110: sl_sh = 64'h1111_2222_3333_4444;
                6'b111011: sl_sh = 64'h1234_5678_9ABC_DEF0;
                6'b111101: sl_sh = 64'hCAFE_0000_BEEF_0001;
                default:   sl_sh = 64'h0;
            endcase
        end else if (ss_n_o == 6'h3F && in_frame) begin
            in_frame = 1'b0;
            log_ssn.push_back(cur_ssn);
            log_w0.push_back(cap[63:48]);
            log_bits.push_back(nbits);
            if (log_ssn.size() == 1) tail = cyc - t_lastfall;
            t_ssrise = cyc;
        end
    end

    // Slave drives miso on sck rise.
    always @(posedge sck) begin
        if (in_frame) begin
            if (log_ssn.size() == 0) begin
                if (nrise == 0) begin
                    setup_lat = cyc - t_fall;
                    t_r0      = cyc;
                end else if (nrise == 1) begin
                    sck_period = cyc - t_r0;
                end
                nrise++;
            end
            miso  = sl_sh[63];
            sl_sh = {sl_sh[62:0], 1'b0};
        end
    end

    // Slave captures mosi on sck fall.
    always @(negedge sck) begin
        if (in_frame) begin
            if (log_ssn.size() == 0 && nbits == 0) sck_high = cyc - t_r0;
            cap        = {cap[62:0], mosi};
            nbits      = nbits + 1;
            t_lastfall = cyc;
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && $countones(~ss_n_o) > 1) multi_sel++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic avs_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic avs_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (log_ssn.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(tag, 32'(log_ssn.size() >= n), 32'd1);
    endtask

    // Wait until ss_n_o equals val, or any select is low when any_low is set.
    task automatic wait_ssn(input logic [5:0] val, input logic any_low, input int budget,
                            input string tag);
        int k = 0;
        while (!(any_low ? (ss_n_o != 6'h3F) : (ss_n_o == val)) && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(tag, 32'(any_low ? (ss_n_o != 6'h3F) : (ss_n_o == val)), 32'd1);
    endtask

    logic [31:0] rd;
    int          n0;
    logic [5:0]  motor_exp;

    initial begin
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_ss_n", 32'(ss_n_o), 32'h3F);
        check("reset_sck", 32'(sck), 32'd0);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_readdata", avs_readdata, 32'd0);
        avs_rd(8'h00, rd); check("reset_ctrl", rd, 32'd0);
        avs_rd(8'h01, rd); check("reset_status", rd, 32'd0);
        avs_rd(8'h02, rd); check("reset_mask", rd, 32'd0);
        avs_rd(8'h10, rd); check("reset_sp0", rd, 32'd0);
        avs_rd(8'h48, rd); check("reset_rx2_0", rd, 32'd0);
        avs_rd(8'h05, rd); check("unmapped_05", rd, 32'd0);
        avs_rd(8'h3F, rd); check("unmapped_3f", rd, 32'd0);

        // Two masked motors, alternating polling.
        avs_wr(8'h10, 32'h0000_A5A5);
        avs_wr(8'h12, 32'h0000_00C3);
        avs_wr(8'h02, 32'h0000_0005);
        avs_rd(8'h02, rd); check("mask_rb", rd, 32'h5);
        avs_rd(8'h12, rd); check("sp2_rb", rd, 32'hC3);
        avs_wr(8'h00, 32'h1);
        wait_frames(3, 12000, "wait_first3");
        check("f0_ssn", 32'(log_ssn[0]), 32'h3E);
        check("f1_ssn", 32'(log_ssn[1]), 32'h3B);
        check("f2_ssn", 32'(log_ssn[2]), 32'h3E);
        check("f0_w0", 32'(log_w0[0]), 32'hA5A5);
        check("f1_w0", 32'(log_w0[1]), 32'h00C3);
        check("f0_bits", 32'(log_bits[0]), 32'd64);
        check("setup_lat", 32'(setup_lat), 32'd25);
        check("sck_period", 32'(sck_period), 32'd50);
        check("sck_high", 32'(sck_high), 32'd25);
        check("tail_lat", 32'(tail), 32'd25);
        check("gap_len", 32'(gap), 32'd50);

        avs_rd(8'h48, rd); check("rx2_0", rd, 32'h1234);
        avs_rd(8'h49, rd); check("rx2_1", rd, 32'h5678);
        avs_rd(8'h4A, rd); check("rx2_2", rd, 32'h9ABC);
        avs_rd(8'h4B, rd); check("rx2_3", rd, 32'hDEF0);
        avs_rd(8'h40, rd); check("rx0_0", rd, 32'h1111);
        avs_rd(8'h43, rd); check("rx0_3", rd, 32'h4444);
        avs_wr(8'h40, 32'hFFFF);
        avs_rd(8'h40, rd); check("rx_ro", rd, 32'h1111);

        // Setpoint change while motor 0 is shifting.
        wait_ssn(6'b111110, 1'b0, 8000, "wait_m0");
        repeat (300) @(posedge clk);
        n0 = log_ssn.size();
        avs_wr(8'h10, 32'h0000_0001);
        wait_frames(n0 + 3, 11000, "wait_sp_frames");
        check("sp_cur_ssn", 32'(log_ssn[n0]), 32'h3E);
        check("sp_cur_w0", 32'(log_w0[n0]), 32'hA5A5);
        check("sp_next_ssn", 32'(log_ssn[n0 + 2]), 32'h3E);
        check("sp_next_w0", 32'(log_w0[n0 + 2]), 32'h0001);

        // Clear enable mid-frame.
        wait_ssn(6'h3F, 1'b1, 4000, "wait_frame_low");
        repeat (300) @(posedge clk);
        n0 = log_ssn.size();
        motor_exp = '0;
        for (int i = 0; i < 6; i++) if (!ss_n_o[i]) motor_exp = 6'(i);
        avs_rd(8'h01, rd);
        check("mid_busy", 32'(rd[0]), 32'd1);
        check("mid_motor", 32'(rd[13:8]), 32'(motor_exp));
        check("mid_count", 32'(rd[31:16]), 32'(n0));
        avs_wr(8'h00, 32'h0);
        wait_ssn(6'h3F, 1'b0, 4000, "wait_release");
        repeat (60) @(posedge clk);
        avs_rd(8'h01, rd);
        check("dis_busy", 32'(rd[0]), 32'd0);
        check("dis_count", 32'(rd[31:16]), 32'(n0 + 1));
        repeat (300) @(posedge clk);
        check("dis_idle_ssn", 32'(ss_n_o), 32'h3F);
        check("dis_frames", 32'(log_ssn.size()), 32'(n0 + 1));

        // Single masked motor repolls.
        n0 = log_ssn.size();
        avs_wr(8'h02, 32'h0000_0002);
        avs_wr(8'h00, 32'h1);
        wait_frames(n0 + 2, 8000, "wait_repoll");
        check("rep0_ssn", 32'(log_ssn[n0]), 32'h3D);
        check("rep1_ssn", 32'(log_ssn[n0 + 1]), 32'h3D);
        check("rep_w0", 32'(log_w0[n0]), 32'h0);
        repeat (5) @(posedge clk);
        avs_rd(8'h44, rd); check("rx1_0", rd, 32'hCAFE);
        avs_rd(8'h47, rd); check("rx1_3", rd, 32'h0001);

        // Reset in the middle of a frame.
        wait_ssn(6'h3F, 1'b1, 4000, "wait_rst_frame");
        repeat (400) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_ss_n", 32'(ss_n_o), 32'h3F);
        check("rst_sck", 32'(sck), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        avs_rd(8'h01, rd); check("rst_status", rd, 32'd0);
        avs_rd(8'h44, rd); check("rst_rx1_0", rd, 32'd0);
        avs_rd(8'h00, rd); check("rst_ctrl", rd, 32'd0);
        check("one_select", 32'(multi_sel), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
